screen_sequencer: RTL and testbench

Top-level screen-mode controller for the VGA path. It sequences the display between the start, game and wait (hand-result) screens and drives the one-hot `start_state` / `game_state` / `wait_state` selects consumed by the screen compositor. Every screen change is committed only at a frame boundary, so no frame ever mixes two screens. It also issues a one-cycle `new_hand` pulse to the poker FSM whenever a hand is to be dealt.

---
 rtl/poker_types_pkg.sv | 15 +
 rtl/frame_tick_gen.sv | 35 +++
 rtl/screen_sequencer.sv | 145 ++++++++++++++
 tb/tb_screen_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_types_pkg.sv
// Shared poker/VGA types: screen-mode encoding decoded by the sequencer,
// the screen compositor and the debug HEX display, plus common widths.
package poker_types_pkg;

  localparam int unsigned PIX_W      = 10;
  localparam int unsigned SCR_W      = 2;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef logic [SCR_W-1:0] screen_state_t;

  localparam screen_state_t SCR_START = 2'd0;
  localparam screen_state_t SCR_GAME  = 2'd1;
  localparam screen_state_t SCR_WAIT  = 2'd2;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame boundary detector: flags the first clk cycle the scan sits at
// pixel (0,0). Fires once per frame even when the pixel clock is slower
// than clk, because the origin must be left and re-entered.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   draw_x_i    - current pixel column
//   draw_y_i    - current pixel row
//   tick_c      - combinational, high in the first cycle at the origin
module frame_tick_gen
  import poker_types_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] draw_x_i,
  input  logic [PIX_W-1:0] draw_y_i,
  output logic             tick_c
);

  logic at_origin_c;
  logic at_origin_q;

  assign at_origin_c = (draw_x_i == '0) && (draw_y_i == '0);

  // Resets to 1 so a scan already parked at the origin gives no tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      at_origin_q <= 1'b1;
    end else begin
      at_origin_q <= at_origin_c;
    end
  end

  assign tick_c = at_origin_c & ~at_origin_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen-mode controller for the VGA path. Sequences START -> GAME -> WAIT
// and commits every screen change on a frame boundary so no frame mixes two
// screens. Pulses new_hand whenever the poker FSM must deal.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   DrawX, DrawY               - current VGA pixel
//   start_req                  - keyboard start request (pulse or level)
//   hand_done                  - poker FSM winner-decided pulse
//   game_over                  - high while any player stack is empty
//   continue_req               - keyboard request to skip the wait screen
//   start_state/game_state/wait_state - registered one-hot screen select
//   new_hand                   - one-cycle deal pulse
//   frame_tick                 - one-cycle pulse, cycle after each boundary
module screen_sequencer
  import poker_types_pkg::*;
#(
  parameter int unsigned WAIT_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] DrawX,
  input  logic [PIX_W-1:0] DrawY,
  input  logic             start_req,
  input  logic             hand_done,
  input  logic             game_over,
  input  logic             continue_req,
  output logic             start_state,
  output logic             game_state,
  output logic             wait_state,
  output logic             new_hand,
  output logic             frame_tick
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_FRAMES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = '1;

  logic                  tick_c;
  screen_state_t         state_q,     state_d;
  logic                  start_pend_q, start_pend_d;
  logic                  done_pend_q,  done_pend_d;
  logic                  cont_pend_q,  cont_pend_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic                  new_hand_q,   new_hand_d;
  logic                  start_sel_q, game_sel_q, wait_sel_q;
  logic                  frame_tick_q;
  logic                  start_eff_c, done_eff_c, cont_eff_c;

  frame_tick_gen u_frame_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .draw_x_i (DrawX),
    .draw_y_i (DrawY),
    .tick_c   (tick_c)
  );

  // Each flag only latches in its own screen; a live input also counts so a
  // request landing on the tick cycle is honoured.
  assign start_eff_c = start_pend_q | start_req;
  assign done_eff_c  = done_pend_q  | hand_done;
  assign cont_eff_c  = cont_pend_q  | continue_req;

  // Next-state, flags, wait counter and deal pulse.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    new_hand_d   = 1'b0;
    start_pend_d = start_pend_q | ((state_q == SCR_START) & start_req);
    done_pend_d  = done_pend_q  | ((state_q == SCR_GAME)  & hand_done);
    cont_pend_d  = cont_pend_q  | ((state_q == SCR_WAIT)  & continue_req);

    if (tick_c) begin
      case (state_q)
        SCR_START: begin
          if (start_eff_c) begin
            state_d    = SCR_GAME;
            new_hand_d = 1'b1;
          end
        end
        SCR_GAME: begin
          if (done_eff_c) begin
            state_d    = SCR_WAIT;
            wait_cnt_d = '0;
          end
        end
        SCR_WAIT: begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
          // Compare the pre-increment count: WAIT spans WAIT_FRAMES ticks.
          if (cont_eff_c || (wait_cnt_q == WAIT_LAST)) begin
            if (game_over) begin
              state_d = SCR_START;
            end else begin
              state_d    = SCR_GAME;
              new_hand_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = SCR_START;
        end
      endcase
    end

    if (state_d != state_q) begin
      start_pend_d = 1'b0;
      done_pend_d  = 1'b0;
      cont_pend_d  = 1'b0;
    end
  end

  // State, flags and registered one-hot decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCR_START;
      start_pend_q <= 1'b0;
      done_pend_q  <= 1'b0;
      cont_pend_q  <= 1'b0;
      wait_cnt_q   <= '0;
      new_hand_q   <= 1'b0;
      start_sel_q  <= 1'b1;
      game_sel_q   <= 1'b0;
      wait_sel_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      done_pend_q  <= done_pend_d;
      cont_pend_q  <= cont_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      new_hand_q   <= new_hand_d;
      start_sel_q  <= (state_d == SCR_START);
      game_sel_q   <= (state_d == SCR_GAME);
      wait_sel_q   <= (state_d == SCR_WAIT);
      frame_tick_q <= tick_c;
    end
  end

  assign start_state = start_sel_q;
  assign game_state  = game_sel_q;
  assign wait_state  = wait_sel_q;
  assign new_hand    = new_hand_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: a small scan model (8 x 12 pixels, one pixel
// every 2 clk), directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a frame-level screen model.
module tb_screen_sequencer;

  localparam int WF   = 3;
  localparam int NPIX = 96;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic       start_req, hand_done, game_over, continue_req;
  logic       start_state, game_state, wait_state, new_hand, frame_tick;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  cmp_en   = 1'b0;
  bit  hold     = 1'b1;
  bit  org_new  = 1'b0;
  int  pix      = 0;
  bit  div      = 1'b0;

  screen_sequencer #(.WAIT_FRAMES(WF)) dut (
    .clk          (clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .start_req    (start_req),
    .hand_done    (hand_done),
    .game_over    (game_over),
    .continue_req (continue_req),
    .start_state  (start_state),
    .game_state   (game_state),
    .wait_state   (wait_state),
    .new_hand     (new_hand),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scan model: columns 0,20,..,140; rows 0,40,..,440; held at 0,0 by hold.
  initial begin
    DrawX = '0;
    DrawY = '0;
    forever begin
      @(negedge clk);
      org_new = 1'b0;
      if (hold) begin
        pix = 0;
        div = 1'b0;
      end else begin
        div = ~div;
        if (!div) begin
          pix = (pix + 1) % NPIX;
          if (pix == 0) org_new = 1'b1;
        end
      end
      DrawX = 10'((pix % 8) * 20);
      DrawY = 10'((pix / 8) * 40);
    end
  end

  // Frame-level reference: one screen, one pending request for that screen,
  // and a count of boundaries seen since entering WAIT.
  int m_scr = 0;      // 0 start, 1 game, 2 wait
  bit m_pend = 1'b0;
  bit m_prev_org = 1'b1;
  int m_frames = 0;
  bit exp_nh = 1'b0;
  bit exp_ft = 1'b0;

  always @(posedge clk) begin : model
    bit org, bnd, req;
    int nxt;
    if (reset) begin
      m_scr = 0; m_pend = 0; m_prev_org = 1; m_frames = 0;
      exp_nh = 0; exp_ft = 0;
    end else begin
      org = (DrawX == 0) && (DrawY == 0);
      bnd = org && !m_prev_org;
      m_prev_org = org;
      case (m_scr)
        0:       req = start_req;
        1:       req = hand_done;
        default: req = continue_req;
      endcase
      req = req | m_pend;
      nxt = m_scr;
      exp_nh = 0;
      exp_ft = bnd;
      if (bnd) begin
        if (m_scr == 0 && req) begin
          nxt = 1; exp_nh = 1;
        end else if (m_scr == 1 && req) begin
          nxt = 2; m_frames = 0;
        end else if (m_scr == 2) begin
          m_frames++;
          if (req || m_frames >= WF) begin
            nxt = game_over ? 0 : 1;
            exp_nh = !game_over;
          end
        end
      end
      m_pend = (nxt != m_scr) ? 1'b0 : req;
      m_scr = nxt;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("start_state", int'(start_state), int'(m_scr == 0));
      check("game_state",  int'(game_state),  int'(m_scr == 1));
      check("wait_state",  int'(wait_state),  int'(m_scr == 2));
      check("new_hand",    int'(new_hand),    int'(exp_nh));
      check("frame_tick",  int'(frame_tick),  int'(exp_ft));
    end
  end

  // Returns in cycle N (inputs set now are sampled with the tick).
  task automatic to_origin();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk); #1;
      if (org_new) found = 1'b1;
    end
    if (!found) check("to_origin_timeout", 0, 1);
  endtask

  task automatic wait_pixel(input int x, input int y);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk); #1;
      if (DrawX == 10'(x) && DrawY == 10'(y)) found = 1'b1;
    end
    if (!found) check("wait_pixel_timeout", 0, 1);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    int cnt, run, wide;
    reset = 1'b1; start_req = 0; hand_done = 0; game_over = 0; continue_req = 0;
    step();
    cmp_en = 1'b1;
    step();
    check("rst_start_state", int'(start_state), 1);
    check("rst_game_state",  int'(game_state),  0);
    check("rst_new_hand",    int'(new_hand),    0);
    @(negedge clk); #1 reset = 1'b0;
    cnt = 0;
    repeat (10) begin step(); cnt += int'(frame_tick); end
    check("held_origin_no_tick", cnt, 0);
    hold = 1'b0;

    // Start pulse mid-frame, acted on at next origin.
    wait_pixel(100, 200);
    start_req = 1'b1; step(); start_req = 1'b0;
    cnt = 0;
    repeat (200) begin step(); cnt += int'(new_hand); end
    check("start_new_hand_count", cnt, 1);
    check("start_game_state", int'(game_state), 1);

    // Start request while in GAME is ignored.
    wait_pixel(40, 80);
    start_req = 1'b1; step(); start_req = 1'b0;
    cnt = 0;
    repeat (250) begin step(); cnt += int'(new_hand); end
    check("game_ignore_start_nh", cnt, 0);
    check("game_ignore_start_gs", int'(game_state), 1);

    // Reset in the middle of GAME with the scan parked at the origin.
    @(negedge clk); #1 reset = 1'b1; hold = 1'b1;
    step();
    check("midrst_start_state", int'(start_state), 1);
    check("midrst_game_state",  int'(game_state),  0);
    check("midrst_wait_state",  int'(wait_state),  0);
    check("midrst_new_hand",    int'(new_hand),    0);
    @(negedge clk); #1 reset = 1'b0;
    cnt = 0;
    repeat (10) begin step(); cnt += int'(frame_tick); end
    check("midrst_no_tick", cnt, 0);
    hold = 1'b0;

    // Enter GAME, then hand_done coincident with the tick.
    to_origin(); start_req = 1'b1; step(); start_req = 1'b0;
    check("deal_game_state", int'(game_state), 1);
    to_origin(); hand_done = 1'b1; step(); hand_done = 1'b0;
    check("coinc_wait_state", int'(wait_state), 1);
    cnt = int'(frame_tick);
    for (int i = 0; i < 1000; i++) begin
      step();
      if (!wait_state) break;
      cnt += int'(frame_tick);
    end
    check("wait_tick_count", cnt, WF);
    check("wait_exit_game", int'(game_state), 1);
    check("wait_exit_nh",   int'(new_hand),   1);

    // Game over at the last WAIT tick.
    to_origin(); hand_done = 1'b1; step(); hand_done = 1'b0;
    to_origin(); to_origin();
    check("go_still_wait", int'(wait_state), 1);
    to_origin(); game_over = 1'b1; step(); game_over = 1'b0;
    check("go_start_state", int'(start_state), 1);
    check("go_new_hand",    int'(new_hand),    0);

    // Skip the wait screen with continue_req during the first WAIT frame.
    to_origin(); start_req = 1'b1; step(); start_req = 1'b0;
    to_origin(); hand_done = 1'b1; step(); hand_done = 1'b0;
    repeat (20) @(negedge clk);
    #1 continue_req = 1'b1; step(); continue_req = 1'b0;
    to_origin(); step();
    check("skip_game_state", int'(game_state), 1);
    check("skip_new_hand",   int'(new_hand),   1);

    // Tick rate over 5 frames, each pulse one cycle wide.
    to_origin();
    cnt = 0; run = 0; wide = 0;
    repeat (5 * 2 * NPIX) begin
      step();
      if (frame_tick) begin cnt++; run++; if (run > 1) wide++; end
      else run = 0;
    end
    check("tick_count_5_frames", cnt, 5);
    check("tick_width", wide, 0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      start_req    = ($urandom_range(0, 99) < 3);
      hand_done    = ($urandom_range(0, 99) < 2);
      continue_req = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 49) == 0) game_over = ~game_over;
      reset        = ($urandom_range(0, 1999) == 0);
    end
    @(negedge clk); #1;
    start_req = 0; hand_done = 0; continue_req = 0; game_over = 0; reset = 0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
